// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the RV32I memory-access stage: funct3 width codes and LSU FSM states.
package mem_access_unit_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    function automatic logic f3_is_legal(input logic we, input logic [2:0] f3);
        logic legal;
        legal = 1'b0;
        case (f3)
            F3_B, F3_H, F3_W: legal = 1'b1;
            F3_BU, F3_HU:     legal = ~we;
            default:          legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/mem_access_unit_align.sv
// Combinational lane logic: store byte enables / lane replication, access error
// detection, and load byte/halfword extraction with sign or zero extension.
module mem_access_unit_align
    import mem_access_unit_pkg::*;
(
    input  logic [2:0]  req_funct3,
    input  logic [1:0]  req_off,
    input  logic        req_we,
    input  logic [31:0] req_wdata,
    output logic [3:0]  req_be,
    output logic [31:0] req_wdata_rep,
    output logic        req_err,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic        misaligned;
    logic [31:0] ld_shifted;

    always_comb begin
        req_be        = 4'h0;
        req_wdata_rep = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                req_be        = 4'b0001 << req_off;
                req_wdata_rep = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                req_be        = 4'b0011 << {req_off[1], 1'b0};
                req_wdata_rep = {2{req_wdata[15:0]}};
            end
            default: begin
                req_be        = 4'hF;
                req_wdata_rep = req_wdata;
            end
        endcase
    end

    always_comb begin
        misaligned = 1'b0;
        case (req_funct3[1:0])
            2'b01:   misaligned = req_off[0];
            2'b10:   misaligned = (req_off != 2'b00);
            default: misaligned = 1'b0;
        endcase
        req_err = misaligned | ~f3_is_legal(req_we, req_funct3);
    end

    // Halfword accesses are already known aligned, so one shift serves both widths.
    assign ld_shifted = ld_rdata >> {ld_off, 3'b000};

    always_comb begin
        ld_data = ld_rdata;
        case (ld_funct3)
            F3_B:    ld_data = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
            F3_BU:   ld_data = {24'h0, ld_shifted[7:0]};
            F3_H:    ld_data = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            F3_HU:   ld_data = {16'h0, ld_shifted[15:0]};
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// RV32I memory-access stage load/store unit: req/gnt/rvalid data-memory sequencing,
// pipeline stall generation, timeout abort and formatted load data for MA/WB.
//
// state | meaning
// IDLE  | no access in flight; accept a legal request from the MA stage
// REQ   | dmem_req held with stable address/data until dmem_gnt
// WAIT  | load granted, waiting for dmem_rvalid
// DONE  | access finished (or aborted); stall released for one cycle
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
)
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_valid,
    input  logic        mem_we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        lsu_stall,
    output logic [31:0] DataR_out,
    output logic        misalign_err,
    output logic        bus_err,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    lsu_state_t        state;
    logic [CNT_W-1:0]  to_cnt;
    logic              to_last;
    logic [2:0]        lat_funct3;
    logic [1:0]        lat_off;

    logic              req_err;
    logic [3:0]        req_be;
    logic [31:0]       req_wdata_rep;
    logic [31:0]       ld_data;

    mem_access_unit_align u_align (
        .req_funct3    (funct3),
        .req_off       (addr[1:0]),
        .req_we        (mem_we),
        .req_wdata     (wdata),
        .req_be        (req_be),
        .req_wdata_rep (req_wdata_rep),
        .req_err       (req_err),
        .ld_funct3     (lat_funct3),
        .ld_off        (lat_off),
        .ld_rdata      (dmem_rdata),
        .ld_data       (ld_data)
    );

    assign to_last      = (to_cnt == CNT_LAST);
    assign misalign_err = mem_valid & req_err;
    assign lsu_stall    = mem_valid & ~req_err & (state != DONE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            to_cnt     <= '0;
            lat_funct3 <= 3'b000;
            lat_off    <= 2'b00;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_be    <= 4'h0;
            dmem_addr  <= 32'h0;
            dmem_wdata <= 32'h0;
            DataR_out  <= 32'h0;
            bus_err    <= 1'b0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_valid) begin
                        if (req_err) begin
                            DataR_out <= 32'h0;
                        end else begin
                            lat_funct3 <= funct3;
                            lat_off    <= addr[1:0];
                            dmem_req   <= 1'b1;
                            dmem_we    <= mem_we;
                            dmem_be    <= req_be;
                            dmem_addr  <= {addr[31:2], 2'b00};
                            dmem_wdata <= req_wdata_rep;
                            to_cnt     <= '0;
                            state      <= REQ;
                        end
                    end
                end
                REQ: begin
                    // A grant on the terminal cycle still wins over the abort.
                    if (dmem_gnt) begin
                        dmem_req <= 1'b0;
                        to_cnt   <= '0;
                        state    <= dmem_we ? DONE : WAIT;
                    end else if (to_last) begin
                        dmem_req <= 1'b0;
                        bus_err  <= 1'b1;
                        if (!dmem_we) begin
                            DataR_out <= 32'h0;
                        end
                        state <= DONE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (dmem_rvalid) begin
                        DataR_out <= ld_data;
                        state     <= DONE;
                    end else if (to_last) begin
                        bus_err   <= 1'b1;
                        DataR_out <= 32'h0;
                        state     <= DONE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, errors, grant stall, timeout and reset abort.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_valid;
    logic        mem_we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    logic        lsu_stall, misalign_err, bus_err, dmem_req, dmem_we;
    logic [31:0] DataR_out, dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;

    logic        t_lsu_stall, t_misalign_err, t_bus_err, t_dmem_req, t_dmem_we;
    logic [31:0] t_DataR_out, t_dmem_addr, t_dmem_wdata;
    logic [3:0]  t_dmem_be;

    int tests_run = 0;
    int tests_failed = 0;

    logic        ma_we   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  ma_f3   [4] = '{3'b001, 3'b010, 3'b011, 3'b100};
    logic [31:0] ma_addr [4] = '{32'h101, 32'h102, 32'h100, 32'h100};

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk(clk), .reset_n(reset_n), .mem_valid(mem_valid), .mem_we(mem_we),
        .funct3(funct3), .addr(addr), .wdata(wdata), .lsu_stall(lsu_stall),
        .DataR_out(DataR_out), .misalign_err(misalign_err), .bus_err(bus_err),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata)
    );

    mem_access_unit #(.TIMEOUT_CYC(4)) dut_to (
        .clk(clk), .reset_n(reset_n), .mem_valid(mem_valid), .mem_we(mem_we),
        .funct3(funct3), .addr(addr), .wdata(wdata), .lsu_stall(t_lsu_stall),
        .DataR_out(t_DataR_out), .misalign_err(t_misalign_err), .bus_err(t_bus_err),
        .dmem_req(t_dmem_req), .dmem_we(t_dmem_we), .dmem_be(t_dmem_be), .dmem_addr(t_dmem_addr),
        .dmem_wdata(t_dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata)
    );

    // Drives one access on the main instance and returns what the memory side saw.
    task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int gw, input int rw, input logic [31:0] rd,
                          output int n, output logic [31:0] o_addr, output logic [3:0] o_be,
                          output logic [31:0] o_wdata, output logic o_we,
                          output logic [31:0] o_data, output bit o_stable, output bit o_done);
        int req_cycles;
        int rv_cnt;
        n = 0; req_cycles = 0; rv_cnt = -1; o_stable = 1'b1; o_done = 1'b0;
        o_addr = 32'h0; o_be = 4'h0; o_wdata = 32'h0; o_we = 1'b0; o_data = 32'h0;
        @(negedge clk);
        mem_valid = 1'b1; mem_we = we; funct3 = f3; addr = a; wdata = wd;
        while (!o_done && n < 60) begin
            #1;
            if (lsu_stall === 1'b0) begin
                o_done = 1'b1;
                o_data = DataR_out;
            end else begin
                n++;
                dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
                if (dmem_req === 1'b1) begin
                    if (req_cycles == 0) begin
                        o_addr = dmem_addr; o_be = dmem_be; o_wdata = dmem_wdata; o_we = dmem_we;
                    end else if ({dmem_addr, dmem_be, dmem_wdata, dmem_we} !== {o_addr, o_be, o_wdata, o_we}) begin
                        o_stable = 1'b0;
                    end
                    if (req_cycles == gw) begin
                        dmem_gnt = 1'b1;
                        if (!we) rv_cnt = rw;
                    end
                    req_cycles++;
                end else if (rv_cnt > 0) begin
                    rv_cnt--;
                    if (rv_cnt == 0) begin
                        dmem_rvalid = 1'b1;
                        dmem_rdata = rd;
                    end
                end
                @(negedge clk);
            end
        end
        mem_valid = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0; mem_valid = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; mem_valid = 1'b0; mem_we = 1'b0; funct3 = 3'b000; addr = 32'h0;
        wdata = 32'h0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        tests_run++;
        if ({dmem_req, dmem_we, dmem_be} !== 6'b0) begin
            tests_failed++; $display("FAIL reset_req_we_be: got %b expected 000000", {dmem_req, dmem_we, dmem_be});
        end
        tests_run++;
        if ({dmem_addr, dmem_wdata} !== 64'h0) begin
            tests_failed++; $display("FAIL reset_addr_wdata: got %h expected 0", {dmem_addr, dmem_wdata});
        end
        tests_run++;
        if (DataR_out !== 32'h0) begin
            tests_failed++; $display("FAIL reset_datar: got %h expected 00000000", DataR_out);
        end
        tests_run++;
        if ({bus_err, lsu_stall, misalign_err} !== 3'b000) begin
            tests_failed++; $display("FAIL reset_flags: got %b expected 000", {bus_err, lsu_stall, misalign_err});
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_load_word();
        int n; logic [31:0] oa, ow, od; logic [3:0] ob; logic owe; bit st, dn;
        access(1'b0, F3_W, 32'h100, 32'h0, 0, 2, 32'hDEADBEEF, n, oa, ob, ow, owe, od, st, dn);
        tests_run++;
        if (!dn || n !== 4) begin
            tests_failed++; $display("FAIL lw_stall_cycles: got %0d (done=%0d) expected 4", n, dn);
        end
        tests_run++;
        if (od !== 32'hDEADBEEF) begin
            tests_failed++; $display("FAIL lw_data: got %h expected deadbeef", od);
        end
        tests_run++;
        if ({oa, ob, owe} !== {32'h100, 4'hF, 1'b0}) begin
            tests_failed++; $display("FAIL lw_request: got addr=%h be=%b we=%b expected 00000100 1111 0", oa, ob, owe);
        end
    endtask

    task automatic test_load_bytes();
        int n; logic [31:0] oa, ow, od; logic [3:0] ob; logic owe; bit st, dn;
        access(1'b0, F3_B, 32'h103, 32'h0, 0, 1, 32'h80112233, n, oa, ob, ow, owe, od, st, dn);
        tests_run++;
        if (!dn || n !== 3 || od !== 32'hFFFFFF80 || oa !== 32'h100 || ob !== 4'b1000) begin
            tests_failed++; $display("FAIL lb: got data=%h n=%0d addr=%h be=%b expected ffffff80 3 00000100 1000", od, n, oa, ob);
        end
        access(1'b0, F3_BU, 32'h103, 32'h0, 0, 1, 32'h80112233, n, oa, ob, ow, owe, od, st, dn);
        tests_run++;
        if (!dn || od !== 32'h00000080) begin
            tests_failed++; $display("FAIL lbu: got %h expected 00000080", od);
        end
        access(1'b0, F3_HU, 32'h102, 32'h0, 0, 1, 32'h80112233, n, oa, ob, ow, owe, od, st, dn);
        tests_run++;
        if (!dn || od !== 32'h00008011 || ob !== 4'b1100) begin
            tests_failed++; $display("FAIL lhu: got data=%h be=%b expected 00008011 1100", od, ob);
        end
    endtask

    task automatic test_store();
        int n; logic [31:0] oa, ow, od; logic [3:0] ob; logic owe; bit st, dn;
        access(1'b1, F3_B, 32'h201, 32'h000000AB, 0, 0, 32'h0, n, oa, ob, ow, owe, od, st, dn);
        tests_run++;
        if (!dn || n !== 2 || {oa, ob, ow, owe} !== {32'h200, 4'b0010, 32'hABABABAB, 1'b1}) begin
            tests_failed++; $display("FAIL sb: got n=%0d addr=%h be=%b wdata=%h we=%b expected 2 00000200 0010 abababab 1", n, oa, ob, ow, owe);
        end
        tests_run++;
        if (od !== 32'h00008011) begin
            tests_failed++; $display("FAIL sb_datar_kept: got %h expected 00008011", od);
        end
        access(1'b1, F3_H, 32'h402, 32'h00001234, 0, 0, 32'h0, n, oa, ob, ow, owe, od, st, dn);
        tests_run++;
        if (!dn || {oa, ob, ow} !== {32'h400, 4'b1100, 32'h12341234}) begin
            tests_failed++; $display("FAIL sh: got addr=%h be=%b wdata=%h expected 00000400 1100 12341234", oa, ob, ow);
        end
        access(1'b1, F3_W, 32'h404, 32'hA5A50F0F, 0, 0, 32'h0, n, oa, ob, ow, owe, od, st, dn);
        tests_run++;
        if (!dn || {oa, ob, ow} !== {32'h404, 4'hF, 32'hA5A50F0F} || od !== 32'h00008011) begin
            tests_failed++; $display("FAIL sw: got addr=%h be=%b wdata=%h datar=%h expected 00000404 1111 a5a50f0f 00008011", oa, ob, ow, od);
        end
    endtask

    task automatic test_misalign();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_valid = 1'b1; mem_we = ma_we[i]; funct3 = ma_f3[i]; addr = ma_addr[i]; wdata = 32'hFFFFFFFF;
            #1;
            tests_run++;
            if ({misalign_err, lsu_stall, dmem_req} !== 3'b100) begin
                tests_failed++; $display("FAIL misalign_%0d: got err/stall/req=%b expected 100", i, {misalign_err, lsu_stall, dmem_req});
            end
            @(negedge clk);
            #1;
            tests_run++;
            if ({misalign_err, dmem_req} !== 2'b10) begin
                tests_failed++; $display("FAIL misalign_noreq_%0d: got err/req=%b expected 10", i, {misalign_err, dmem_req});
            end
            mem_valid = 1'b0;
        end
        tests_run++;
        if (DataR_out !== 32'h0) begin
            tests_failed++; $display("FAIL misalign_datar: got %h expected 00000000", DataR_out);
        end
    endtask

    task automatic test_back_to_back();
        int n1, n2; logic [31:0] oa, ow, od1, od2; logic [3:0] ob; logic owe; bit st, dn1, dn2;
        access(1'b0, F3_W, 32'h500, 32'h0, 0, 1, 32'h11112222, n1, oa, ob, ow, owe, od1, st, dn1);
        access(1'b0, F3_H, 32'h502, 32'h0, 0, 1, 32'h80010000, n2, oa, ob, ow, owe, od2, st, dn2);
        tests_run++;
        if (!dn1 || !dn2 || n1 !== 3 || n2 !== 3) begin
            tests_failed++; $display("FAIL b2b_latency: got %0d,%0d expected 3,3", n1, n2);
        end
        tests_run++;
        if (od1 !== 32'h11112222 || od2 !== 32'hFFFF8001) begin
            tests_failed++; $display("FAIL b2b_data: got %h,%h expected 11112222,ffff8001", od1, od2);
        end
    endtask

    task automatic test_gnt_stall();
        int n; logic [31:0] oa, ow, od; logic [3:0] ob; logic owe; bit st, dn;
        access(1'b1, F3_W, 32'h600, 32'h0BADF00D, 5, 0, 32'h0, n, oa, ob, ow, owe, od, st, dn);
        tests_run++;
        if (!dn || n !== 7) begin
            tests_failed++; $display("FAIL gnt_wait_stall: got %0d (done=%0d) expected 7", n, dn);
        end
        tests_run++;
        if (!st || {oa, ob, ow} !== {32'h600, 4'hF, 32'h0BADF00D}) begin
            tests_failed++; $display("FAIL gnt_wait_stable: got stable=%0d addr=%h wdata=%h expected 1 00000600 0badf00d", st, oa, ow);
        end
    endtask

    task automatic test_timeout();
        int n; logic [31:0] oa, ow, od; logic [3:0] ob; logic owe; bit st, dn;
        int seen_at, pulses, main_pulses;
        logic [31:0] data_at;
        apply_reset();
        access(1'b0, F3_W, 32'h700, 32'h0, 0, 1, 32'h12345678, n, oa, ob, ow, owe, od, st, dn);
        @(negedge clk);
        tests_run++;
        if (t_DataR_out !== 32'h12345678) begin
            tests_failed++; $display("FAIL to_preload: got %h expected 12345678", t_DataR_out);
        end
        seen_at = -1; pulses = 0; main_pulses = 0; data_at = 32'hFFFFFFFF;
        mem_valid = 1'b1; mem_we = 1'b0; funct3 = F3_W; addr = 32'h704;
        for (int k = 0; k < 12; k++) begin
            #1;
            if (t_bus_err === 1'b1) begin
                pulses++;
                if (seen_at < 0) begin
                    seen_at = k;
                    data_at = t_DataR_out;
                end
            end
            if (bus_err === 1'b1) main_pulses++;
            dmem_gnt = (k == 1);
            if (t_lsu_stall === 1'b0) mem_valid = 1'b0;
            @(negedge clk);
        end
        tests_run++;
        if (seen_at !== 6 || pulses !== 1) begin
            tests_failed++; $display("FAIL to_bus_err: got first=%0d pulses=%0d expected 6 1", seen_at, pulses);
        end
        tests_run++;
        if (data_at !== 32'h0) begin
            tests_failed++; $display("FAIL to_datar: got %h expected 00000000", data_at);
        end
        tests_run++;
        if (main_pulses !== 0 || lsu_stall !== 1'b0 || dmem_req !== 1'b0) begin
            tests_failed++; $display("FAIL to_long_limit: got pulses=%0d expected 0", main_pulses);
        end
    endtask

    task automatic test_reset_mid();
        int n; logic [31:0] oa, ow, od; logic [3:0] ob; logic owe; bit st, dn;
        apply_reset();
        @(negedge clk);
        mem_valid = 1'b1; mem_we = 1'b0; funct3 = F3_W; addr = 32'h800;
        @(negedge clk);
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        #1;
        reset_n = 1'b0; mem_valid = 1'b0;
        @(negedge clk);
        #1;
        tests_run++;
        if ({dmem_req, lsu_stall} !== 2'b00) begin
            tests_failed++; $display("FAIL rst_mid_req: got req/stall=%b expected 00", {dmem_req, lsu_stall});
        end
        reset_n = 1'b1; dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        #1;
        tests_run++;
        if (DataR_out !== 32'h0 || dmem_req !== 1'b0) begin
            tests_failed++; $display("FAIL rst_mid_stale: got datar=%h req=%b expected 00000000 0", DataR_out, dmem_req);
        end
        access(1'b0, F3_BU, 32'h801, 32'h0, 0, 1, 32'h00005A00, n, oa, ob, ow, owe, od, st, dn);
        tests_run++;
        if (!dn || n !== 3 || od !== 32'h0000005A) begin
            tests_failed++; $display("FAIL rst_mid_next: got n=%0d data=%h expected 3 0000005a", n, od);
        end
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_load_bytes();
        test_store();
        test_misalign();
        test_back_to_back();
        test_gnt_stall();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
